crc_stream_feeder: RTL and testbench

Avalon-MM bus-master engine that computes a CRC over a memory buffer without CPU involvement. The Nios II programs a start address and byte length through a small CSR slave. The block then reads the buffer word by word over its read master and streams the data into the CRC component's Avalon slave: an init write, then 8/16/32-bit data writes, then a 32-bit result read. The captured result is presented back in a CSR, with an optional interrupt. It sits directly upstream of the CRC component and is used for firmware-image integrity checks.

---
 rtl/crc_stream_feeder.sv | 230 +++++++++++++++++++++++
 tb/tb_crc_stream_feeder.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_feeder.sv
// crc_stream_feeder
//   Avalon-MM bus-master engine that walks a memory buffer word by word and
//   streams it into the CRC component's slave: init write, data writes
//   (byteenable 1111 / 0011 / 0001), then a result read. The captured result
//   is exposed through a 4-word CSR slave with an optional level interrupt.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   csr_*                 CSR slave: 0 START_ADDR, 1 LENGTH, 2 CTRL/STATUS, 3 RESULT
//   irq                   done & irq_en
//   m_*                   read master (word aligned, one read outstanding)
//   crc_*                 write/read master into the CRC component slave
module crc_stream_feeder #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic [2:0]        crc_address,
    output logic [31:0]       crc_writedata,
    output logic [3:0]        crc_byteenable,
    output logic              crc_write,
    output logic              crc_read,
    output logic              crc_chipselect,
    input  logic [31:0]       crc_readdata
);

    typedef enum logic [2:0] {
        IDLE, INIT, RD_REQ, RD_WAIT, FEED, FEED_TAIL, RES_RD, RES_CAP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
    logic [LEN_W-1:0]    length_q, length_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic [31:0]         result_q, result_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [31:0]         word_q, word_d;

    // Bus outputs are registered, computed from the next state.
    logic                m_read_q, m_read_d;
    logic [ADDR_W-1:0]   m_address_q, m_address_d;
    logic                crc_write_q, crc_write_d;
    logic                crc_read_q, crc_read_d;
    logic [2:0]          crc_address_q, crc_address_d;
    logic [3:0]          crc_byteenable_q, crc_byteenable_d;
    logic [31:0]         crc_writedata_q, crc_writedata_d;

    logic busy;
    logic wr_start, wr_len, wr_ctrl, go;

    // CSR reads are combinational and side-effect free, so the strobe is not needed.
    logic unused_csr_read;
    assign unused_csr_read = csr_read;

    assign busy     = (state_q != IDLE);
    assign wr_start = csr_write && (csr_address == 2'd0) && !busy;
    assign wr_len   = csr_write && (csr_address == 2'd1) && !busy;
    assign wr_ctrl  = csr_write && (csr_address == 2'd2);
    assign go       = wr_ctrl && csr_writedata[0] && !busy;

    always_comb begin
        state_d          = state_q;
        start_addr_d     = start_addr_q;
        length_d         = length_q;
        irq_en_d         = irq_en_q;
        done_d           = done_q;
        result_d         = result_q;
        addr_d           = addr_q;
        rem_d            = rem_q;
        word_d           = word_q;
        m_read_d         = 1'b0;
        m_address_d      = '0;
        crc_write_d      = 1'b0;
        crc_read_d       = 1'b0;
        crc_address_d    = 3'd0;
        crc_byteenable_d = 4'b0000;
        crc_writedata_d  = 32'h0;

        if (wr_start) start_addr_d = {csr_writedata[ADDR_W-1:2], 2'b00};
        if (wr_len)   length_d     = csr_writedata[LEN_W-1:0];
        if (wr_ctrl) begin
            irq_en_d = csr_writedata[1];
            if (csr_writedata[2]) done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    addr_d  = start_addr_q;
                    rem_d   = length_q;
                    done_d  = 1'b0;
                    state_d = INIT;
                end
            end
            INIT:    state_d = (rem_q != '0) ? RD_REQ : RES_RD;
            RD_REQ:  if (!m_waitrequest) state_d = RD_WAIT;
            RD_WAIT: begin
                if (m_readdatavalid) begin
                    word_d  = m_readdata;
                    state_d = FEED;
                end
            end
            FEED: begin
                if (rem_q >= LEN_W'(4)) begin
                    rem_d   = rem_q - LEN_W'(4);
                    addr_d  = addr_q + ADDR_W'(4);
                    state_d = (rem_q == LEN_W'(4)) ? RES_RD : RD_REQ;
                end else if (rem_q == LEN_W'(3)) begin
                    // Third byte goes out alone from lane 2 in FEED_TAIL.
                    rem_d   = '0;
                    state_d = FEED_TAIL;
                end else begin
                    rem_d   = '0;
                    state_d = RES_RD;
                end
            end
            FEED_TAIL: state_d = RES_RD;
            RES_RD:    state_d = RES_CAP;
            RES_CAP: begin
                result_d = crc_readdata;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default:   state_d = IDLE;
        endcase

        case (state_d)
            INIT: begin
                crc_write_d   = 1'b1;
                crc_address_d = 3'd0;
            end
            RD_REQ: begin
                m_read_d    = 1'b1;
                m_address_d = addr_d;
            end
            FEED: begin
                // Entered only from RD_WAIT, so rem_q is the count for this word.
                crc_write_d      = 1'b1;
                crc_address_d    = 3'd1;
                crc_writedata_d  = word_d;
                crc_byteenable_d = (rem_q >= LEN_W'(4)) ? 4'b1111 :
                                   (rem_q >= LEN_W'(2)) ? 4'b0011 : 4'b0001;
            end
            FEED_TAIL: begin
                crc_write_d      = 1'b1;
                crc_address_d    = 3'd1;
                crc_writedata_d  = {24'h0, word_q[23:16]};
                crc_byteenable_d = 4'b0001;
            end
            RES_RD: begin
                crc_read_d    = 1'b1;
                crc_address_d = 3'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            start_addr_q     <= '0;
            length_q         <= '0;
            irq_en_q         <= 1'b0;
            done_q           <= 1'b0;
            result_q         <= 32'h0;
            addr_q           <= '0;
            rem_q            <= '0;
            word_q           <= 32'h0;
            m_read_q         <= 1'b0;
            m_address_q      <= '0;
            crc_write_q      <= 1'b0;
            crc_read_q       <= 1'b0;
            crc_address_q    <= 3'd0;
            crc_byteenable_q <= 4'b0000;
            crc_writedata_q  <= 32'h0;
        end else begin
            state_q          <= state_d;
            start_addr_q     <= start_addr_d;
            length_q         <= length_d;
            irq_en_q         <= irq_en_d;
            done_q           <= done_d;
            result_q         <= result_d;
            addr_q           <= addr_d;
            rem_q            <= rem_d;
            word_q           <= word_d;
            m_read_q         <= m_read_d;
            m_address_q      <= m_address_d;
            crc_write_q      <= crc_write_d;
            crc_read_q       <= crc_read_d;
            crc_address_q    <= crc_address_d;
            crc_byteenable_q <= crc_byteenable_d;
            crc_writedata_q  <= crc_writedata_d;
        end
    end

    always_comb begin
        csr_readdata = 32'h0;
        case (csr_address)
            2'd0:    csr_readdata[ADDR_W-1:0] = start_addr_q;
            2'd1:    csr_readdata[LEN_W-1:0]  = length_q;
            2'd2:    csr_readdata[2:0]        = {irq_en_q, done_q, busy};
            default: csr_readdata             = result_q;
        endcase
    end

    assign irq            = done_q & irq_en_q;
    assign m_read         = m_read_q;
    assign m_address      = m_address_q;
    assign crc_write      = crc_write_q;
    assign crc_read       = crc_read_q;
    assign crc_chipselect = crc_write_q | crc_read_q;
    assign crc_address    = crc_address_q;
    assign crc_byteenable = crc_byteenable_q;
    assign crc_writedata  = crc_writedata_q;

endmodule

// File: tb/tb_crc_stream_feeder.sv
// Testbench for crc_stream_feeder: memory read slave with random stalls and
// readdatavalid delays, a CRC-32 slave model, and a scoreboard of expected
// CRC-slave accesses pushed before each transfer and popped as they appear.
module tb_crc_stream_feeder;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        csr_address;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic              csr_read;
    logic [31:0]       csr_readdata;
    logic              irq;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_waitrequest;
    logic [31:0]       m_readdata;
    logic              m_readdatavalid;
    logic [2:0]        crc_address;
    logic [31:0]       crc_writedata;
    logic [3:0]        crc_byteenable;
    logic              crc_write;
    logic              crc_read;
    logic              crc_chipselect;
    logic [31:0]       crc_readdata;

    always #5 clk = ~clk;

    crc_stream_feeder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_read(csr_read),
        .csr_readdata(csr_readdata), .irq(irq),
        .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .crc_address(crc_address), .crc_writedata(crc_writedata),
        .crc_byteenable(crc_byteenable), .crc_write(crc_write),
        .crc_read(crc_read), .crc_chipselect(crc_chipselect),
        .crc_readdata(crc_readdata)
    );

    typedef struct {
        logic        is_read;
        logic [2:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    exp_t        sb_q[$];
    logic [7:0]  mem [256];
    int          max_stall = 0;
    int          max_delay = 0;
    int          reads_accepted = 0;
    logic [31:0] crc_acc;

    logic        s_pending;
    int          s_cnt;
    logic [31:0] s_word;
    int          s_stall_left;
    logic        s_prev_stalled;
    logic [31:0] s_prev_addr;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] ref_crc(input int base, input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) c = crc_byte(c, mem[(base + i) & 255]);
        return c ^ 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        return {mem[(a + 3) & 255], mem[(a + 2) & 255], mem[(a + 1) & 255], mem[a & 255]};
    endfunction

    function automatic void sb_push(input logic r, input logic [2:0] a, input logic [3:0] be,
                                    input logic [31:0] d);
        exp_t e;
        e.is_read = r; e.addr = a; e.be = be; e.data = d;
        sb_q.push_back(e);
    endfunction

    // Expected CRC-slave access sequence for one transfer.
    task automatic push_xfer(input int base, input int len);
        int a;
        int rem;
        logic [31:0] w;
        a = base & ~3;
        rem = len;
        sb_push(1'b0, 3'd0, 4'h0, 32'h0);
        while (rem > 0) begin
            w = mem_word(a);
            if (rem >= 4) begin
                sb_push(1'b0, 3'd1, 4'hF, w); rem -= 4; a += 4;
            end else if (rem == 3) begin
                sb_push(1'b0, 3'd1, 4'h3, w);
                sb_push(1'b0, 3'd1, 4'h1, {24'h0, w[23:16]});
                rem = 0;
            end else if (rem == 2) begin
                sb_push(1'b0, 3'd1, 4'h3, w); rem = 0;
            end else begin
                sb_push(1'b0, 3'd1, 4'h1, w); rem = 0;
            end
        end
        sb_push(1'b1, 3'd4, 4'h0, 32'h0);
    endtask

    // CRC slave model + scoreboard consumer.
    initial begin
        exp_t e;
        logic [40:0] obs, req;
        crc_readdata = 32'h0;
        crc_acc = 32'hFFFFFFFF;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && (crc_write === 1'b1 || crc_read === 1'b1)) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL crc_unexpected: got w=%0b r=%0b addr=%0d be=%b data=%h, expected no access",
                             crc_write, crc_read, crc_address, crc_byteenable, crc_writedata);
                end else begin
                    e = sb_q.pop_front();
                    obs = {crc_read, crc_chipselect, crc_address, crc_byteenable,
                           (crc_address == 3'd1) ? crc_writedata : 32'h0};
                    req = {e.is_read, 1'b1, e.addr, e.be, (e.addr == 3'd1) ? e.data : 32'h0};
                    if (obs !== req) begin
                        tests_failed++;
                        $display("FAIL crc_access: got %h, expected %h", obs, req);
                    end
                end
                if (crc_write === 1'b1 && crc_address == 3'd0) crc_acc = 32'hFFFFFFFF;
                else if (crc_write === 1'b1 && crc_address == 3'd1)
                    for (int k = 0; k < 4; k++)
                        if (crc_byteenable[k]) crc_acc = crc_byte(crc_acc, crc_writedata[8*k +: 8]);
                if (crc_read === 1'b1) crc_readdata = crc_acc ^ 32'hFFFFFFFF;
            end
        end
    end

    // Memory read slave: random stalls, delayed readdatavalid, stability checks.
    initial begin
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'h0;
        s_pending = 1'b0; s_cnt = 0; s_word = 32'h0; s_stall_left = 0;
        s_prev_stalled = 1'b0; s_prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            m_readdatavalid = 1'b0;
            if (s_pending) begin
                if (s_cnt == 0) begin
                    m_readdatavalid = 1'b1; m_readdata = s_word; s_pending = 1'b0;
                end else s_cnt--;
            end
            if (s_prev_stalled) begin
                tests_run++;
                if (m_read !== 1'b1 || m_address !== s_prev_addr) begin
                    tests_failed++;
                    $display("FAIL mread_stable: got read=%0b addr=%h, expected read=1 addr=%h",
                             m_read, m_address, s_prev_addr);
                end
            end
            m_waitrequest = 1'b0;
            s_prev_stalled = 1'b0;
            if (m_read === 1'b1) begin
                if (s_stall_left > 0) begin
                    m_waitrequest = 1'b1; s_stall_left--;
                    s_prev_stalled = 1'b1; s_prev_addr = m_address;
                end else begin
                    tests_run++;
                    if (s_pending || m_address[1:0] !== 2'b00) begin
                        tests_failed++;
                        $display("FAIL read_accept: got outstanding=%0b addr=%h, expected 0 and aligned",
                                 s_pending, m_address);
                    end
                    s_pending = 1'b1;
                    s_cnt = int'($urandom_range(max_delay, 0));
                    s_word = mem_word(int'(m_address));
                    reads_accepted++;
                    s_stall_left = int'($urandom_range(max_stall, 0));
                end
            end
        end
    end

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0; csr_writedata = 32'h0; csr_address = 2'd0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        #1;
        d = csr_readdata;
        csr_read = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        int n;
        n = 0;
        csr_rd(2'd2, s);
        while (s[1] !== 1'b1 && n < 3000) begin
            @(negedge clk); csr_rd(2'd2, s); n++;
        end
        tests_run++;
        if (s[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_timeout: got status %h, expected done", name, s);
        end
    endtask

    task automatic run_xfer(input string name, input int base, input int len, input logic [31:0] res);
        logic [31:0] s;
        csr_wr(2'd0, base);
        csr_wr(2'd1, len);
        push_xfer(base, len);
        csr_wr(2'd2, 32'h1);
        wait_done(name);
        csr_rd(2'd3, s);
        tests_run++;
        if (s !== res) begin
            tests_failed++;
            $display("FAIL %s_result: got %h, expected %h", name, s, res);
        end
        csr_rd(2'd2, s);
        tests_run++;
        if (s[1:0] !== 2'b10 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_status: got status %h pending %0d, expected done idle 0", name, s, sb_q.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({irq, m_read, m_address, crc_write, crc_read, crc_chipselect, crc_byteenable} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got irq=%0b rd=%0b addr=%h w=%0b r=%0b cs=%0b be=%b, expected all 0",
                     irq, m_read, m_address, crc_write, crc_read, crc_chipselect, crc_byteenable);
        end
        for (int i = 0; i < 4; i++) begin
            csr_rd(2'(i), s);
            tests_run++;
            if (s !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_csr%0d: got %h, expected 0", i, s);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known9();
        logic [31:0] s;
        string str;
        str = "123456789";
        for (int i = 0; i < 9; i++) mem[16 + i] = str[i];
        csr_wr(2'd0, 32'h13);
        csr_rd(2'd0, s);
        tests_run++;
        if (s !== 32'h10) begin
            tests_failed++;
            $display("FAIL start_addr_align: got %h, expected 00000010", s);
        end
        csr_wr(2'd1, 32'hFF00_0009);
        csr_rd(2'd1, s);
        tests_run++;
        if (s !== 32'h9) begin
            tests_failed++;
            $display("FAIL length_width: got %h, expected 00000009", s);
        end
        run_xfer("known9", 16, 9, 32'hCBF43926);
    endtask

    task automatic test_abc();
        mem[64] = 8'h61; mem[65] = 8'h62; mem[66] = 8'h63; mem[67] = 8'h5A;
        run_xfer("abc", 64, 3, 32'h352441C2);
    endtask

    task automatic test_len0();
        logic [31:0] s;
        int r0;
        r0 = reads_accepted;
        csr_wr(2'd0, 32'h60);
        csr_wr(2'd1, 32'h0);
        push_xfer(96, 0);
        csr_wr(2'd2, 32'h5);      // go together with clear-done: go must still start
        tests_run++;
        if ({crc_write, crc_address, crc_byteenable} !== {1'b1, 3'd0, 4'h0}) begin
            tests_failed++;
            $display("FAIL len0_init: got w=%0b addr=%0d be=%b, expected w=1 addr=0 be=0000",
                     crc_write, crc_address, crc_byteenable);
        end
        @(negedge clk);
        tests_run++;
        if ({crc_read, crc_address} !== {1'b1, 3'd4}) begin
            tests_failed++;
            $display("FAIL len0_resrd: got r=%0b addr=%0d, expected r=1 addr=4", crc_read, crc_address);
        end
        @(negedge clk); csr_rd(2'd2, s);
        tests_run++;
        if (s[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL len0_done_early: got status %h, expected done=0", s);
        end
        @(negedge clk); csr_rd(2'd2, s);
        tests_run++;
        if (s[2:0] !== 3'b010) begin
            tests_failed++;
            $display("FAIL len0_done: got status %h, expected 2", s);
        end
        csr_rd(2'd3, s);
        tests_run++;
        if (s !== 32'h0 || reads_accepted != r0 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL len0_result: got res=%h reads=%0d pending=%0d, expected 0 0 0",
                     s, reads_accepted - r0, sb_q.size());
        end
    endtask

    task automatic test_random_stalls();
        for (int i = 0; i < 64; i++) mem[128 + i] = 8'($urandom);
        max_stall = 5; max_delay = 3;
        run_xfer("random64", 128, 64, ref_crc(128, 64));
        max_stall = 0; max_delay = 0;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] s;
        logic pre_irq, seen;
        for (int i = 0; i < 8; i++) mem[192 + i] = 8'($urandom);
        max_stall = 5; max_delay = 3;
        csr_wr(2'd0, 32'hC0);
        csr_wr(2'd1, 32'h8);
        push_xfer(192, 8);
        csr_wr(2'd2, 32'h3);
        csr_wr(2'd0, 32'h20);
        csr_wr(2'd1, 32'h5);
        csr_wr(2'd2, 32'h3);
        csr_rd(2'd2, s);
        tests_run++;
        if (s[0] !== 1'b1 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_status: got status %h irq %0b, expected busy=1 irq=0", s, irq);
        end
        pre_irq = irq; seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk); csr_rd(2'd2, s);
            if (s[1] === 1'b1) seen = 1'b1; else pre_irq = irq;
        end
        tests_run++;
        if ({seen, pre_irq, irq} !== 3'b101) begin
            tests_failed++;
            $display("FAIL irq_rise: got seen=%0b before=%0b at_done=%0b, expected 1 0 1", seen, pre_irq, irq);
        end
        csr_rd(2'd3, s);
        tests_run++;
        if (s !== ref_crc(192, 8)) begin
            tests_failed++;
            $display("FAIL busy_result: got %h, expected %h", s, ref_crc(192, 8));
        end
        csr_rd(2'd0, s);
        tests_run++;
        if (s !== 32'hC0) begin
            tests_failed++;
            $display("FAIL busy_start_kept: got %h, expected 000000c0", s);
        end
        csr_rd(2'd1, s);
        tests_run++;
        if (s !== 32'h8 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL busy_length_kept: got %h pending %0d, expected 8 0", s, sb_q.size());
        end
        csr_wr(2'd2, 32'h6);
        csr_rd(2'd2, s);
        tests_run++;
        if ({irq, s[2:0]} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL irq_clear: got irq=%0b status=%h, expected irq=0 status=4", irq, s);
        end
        csr_wr(2'd2, 32'h0);
        max_stall = 0; max_delay = 0;
    endtask

    task automatic test_reset_midway();
        logic [31:0] s;
        int r0;
        logic got;
        max_stall = 0; max_delay = 3;
        r0 = reads_accepted;
        csr_wr(2'd0, 32'h80);
        csr_wr(2'd1, 32'h8);
        sb_push(1'b0, 3'd0, 4'h0, 32'h0);   // only the init write may appear
        csr_wr(2'd2, 32'h1);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk); #2;
            if (reads_accepted != r0) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL midreset_no_read: got no accepted read, expected one");
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({irq, m_read, m_address, crc_write, crc_read, crc_chipselect, crc_byteenable} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got rd=%0b addr=%h w=%0b r=%0b cs=%0b be=%b, expected all 0",
                     m_read, m_address, crc_write, crc_read, crc_chipselect, crc_byteenable);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        csr_rd(2'd2, s);
        tests_run++;
        if (s !== 32'h0 || sb_q.size() != 0 || reads_accepted != r0 + 1) begin
            tests_failed++;
            $display("FAIL midreset_idle: got status %h pending %0d reads %0d, expected 0 0 1",
                     s, sb_q.size(), reads_accepted - r0);
        end
        max_delay = 0;
        run_xfer("after_reset", 64, 3, 32'h352441C2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        csr_address = 2'd0; csr_write = 1'b0; csr_writedata = 32'h0; csr_read = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        test_reset();
        test_known9();
        test_abc();
        test_len0();
        test_random_stalls();
        test_busy_ignore();
        test_reset_midway();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
